// File: rtl/instr_sequencer_if.sv
// instr_sequencer_if: instruction/ALU status inputs and datapath select/enable outputs of the sequencer
// master: sequencer side (drives selects/enables, reads Instr/ALUFlags/Finished)
// slave: datapath side
interface instr_sequencer_if;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
  logic        Finished;
  logic [1:0]  RegSrc;
  logic [1:0]  ImmSrc;
  logic        ALUSrc;
  logic [3:0]  ALUControl;
  logic        MemToReg;
  logic        PCSrc;
  logic        RegWrite;
  logic        MemWrite;
  logic        PCWrite;
  logic        Busy;
  logic        Fault;
  modport master (
    input  Instr, ALUFlags, Finished,
    output RegSrc, ImmSrc, ALUSrc, ALUControl, MemToReg, PCSrc,
    output RegWrite, MemWrite, PCWrite, Busy, Fault
  );
  modport slave (
    output Instr, ALUFlags, Finished,
    input  RegSrc, ImmSrc, ALUSrc, ALUControl, MemToReg, PCSrc,
    input  RegWrite, MemWrite, PCWrite, Busy, Fault
  );
endinterface

// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle ARM-subset control unit with NZCV flags, conditional execution and ALU timeout trap
// clk, reset (async active-low); bus: instr_sequencer_if.master carrying Instr/ALUFlags/Finished in,
// datapath selects, write enables, Busy and Fault out
module instr_sequencer #(
  parameter int unsigned ALU_TIMEOUT = 15
) (
  input logic               clk,
  input logic               reset,
  instr_sequencer_if.master bus
);
  typedef enum logic [1:0] {DECODE, EXEC, COMMIT, FAULT} state_t;
  state_t     state_q;
  logic [3:0] flags_q, pend_q;
  logic [7:0] cnt_q;
  logic       condex_q, regwrite_q, memwrite_q, pcwrite_q, busy_q, fault_q;
  logic [3:0] cond, cmd, rd;
  logic [1:0] op;
  logic [5:0] funct;
  logic       dp, mem, br, ldr, str, wr_rd, pc_rd, s_upd, n, z, c, v, condex_d;
  logic [15:0] cond_tab;
  logic [8:0] cnt_d;
  logic       unused_bits;
  assign {cond, op, funct} = bus.Instr[31:20];
  assign rd = bus.Instr[15:12];
  assign unused_bits = ^{bus.Instr[19:16], bus.Instr[11:0]};
  assign cmd = funct[4:1];
  assign dp = op == 2'b00;
  assign mem = op == 2'b01;
  assign br = op == 2'b10;
  assign ldr = mem & funct[0];
  assign str = mem & ~funct[0];
  assign wr_rd = (dp & cmd != 4'b1010 & cmd != 4'b1000) | ldr;
  assign pc_rd = wr_rd & rd == 4'hf;
  assign s_upd = dp & funct[0];
  assign {n, z, c, v} = flags_q;
  // Indexed by the condition field: bit 0 is EQ, bit 15 is "never".
  assign cond_tab = {1'b0, 1'b1, z | (n ^ v), ~z & ~(n ^ v), n ^ v, ~(n ^ v), ~c | z, c & ~z,
                     ~v, v, ~n, n, ~c, c, ~z, z};
  assign condex_d = cond_tab[cond] & ~(op == 2'b11);
  assign cnt_d = {1'b0, cnt_q} + 9'd1;
  assign bus.ALUControl = dp ? cmd : 4'b0100;
  assign bus.ALUSrc = dp ? funct[5] : 1'b1;
  assign bus.ImmSrc = mem ? 2'b01 : br ? 2'b10 : 2'b00;
  assign bus.RegSrc = str ? 2'b10 : br ? 2'b01 : 2'b00;
  assign bus.MemToReg = ldr;
  // A skipped instruction must still fall through to PC+4.
  assign bus.PCSrc = (br | pc_rd) & ~(state_q == COMMIT & ~condex_q);
  assign bus.RegWrite = regwrite_q;
  assign bus.MemWrite = memwrite_q;
  assign bus.PCWrite = pcwrite_q;
  assign bus.Busy = busy_q;
  assign bus.Fault = fault_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= DECODE;
      flags_q    <= '0;
      pend_q     <= '0;
      cnt_q      <= '0;
      condex_q   <= 1'b0;
      regwrite_q <= 1'b0;
      memwrite_q <= 1'b0;
      pcwrite_q  <= 1'b0;
      busy_q     <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      case (state_q)
        DECODE: begin
          condex_q <= condex_d;
          cnt_q    <= '0;
          state_q  <= condex_d ? EXEC : COMMIT;
          busy_q   <= condex_d;
          pcwrite_q <= ~condex_d;
        end
        EXEC: begin
          if (bus.Finished) begin
            pend_q     <= bus.ALUFlags;
            state_q    <= COMMIT;
            busy_q     <= 1'b0;
            pcwrite_q  <= 1'b1;
            regwrite_q <= wr_rd & ~pc_rd;
            memwrite_q <= str;
          end else begin
            cnt_q <= cnt_d[7:0];
            if (cnt_d == 9'(ALU_TIMEOUT)) begin
              state_q <= FAULT;
              busy_q  <= 1'b0;
              fault_q <= 1'b1;
            end
          end
        end
        COMMIT: begin
          if (condex_q & s_upd) flags_q <= pend_q;
          pcwrite_q  <= 1'b0;
          regwrite_q <= 1'b0;
          memwrite_q <= 1'b0;
          state_q    <= DECODE;
        end
        default: state_q <= FAULT;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed checks of decode, timing, conditional execution and timeout fault
module tb_instr_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  logic [12:0] sel;
  int cyc;
  logic [15:0] bm, rm;
  logic [12:0] com;
  logic pw;
  instr_sequencer_if bus();
  instr_sequencer #(.ALU_TIMEOUT(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  // {RegWrite, MemWrite, PCSrc, MemToReg, RegSrc, ImmSrc, ALUSrc, ALUControl}
  assign sel = {bus.RegWrite, bus.MemWrite, bus.PCSrc, bus.MemToReg, bus.RegSrc, bus.ImmSrc,
                bus.ALUSrc, bus.ALUControl};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // Runs one instruction from DECODE; Finished goes high from EXEC cycle k on (k=0: never).
  task automatic run(input logic [31:0] ins, input int k, input logic [3:0] fl, output int cy,
                     output logic [15:0] b, output logic [15:0] r, output logic [12:0] cm);
    cy = 0;
    b = '0;
    r = '0;
    cm = '0;
    bus.Instr = ins;
    bus.ALUFlags = fl;
    for (int c = 1; c < 16; c++) begin
      bus.Finished = (k > 0) && (c > k);
      #1;
      b[c] = bus.Busy;
      r[c] = bus.RegWrite;
      if (bus.PCWrite) begin
        cy = c;
        cm = sel;
      end
      tick;
      if (cy != 0) break;
    end
    bus.Finished = 1'b0;
  endtask
  initial begin
    bus.Instr = 32'hE2821005;
    bus.ALUFlags = 4'h0;
    bus.Finished = 1'b0;
    #12;
    chk("rst_fault", bus.Fault, 0);
    chk("rst_busy", bus.Busy, 0);
    chk("rst_pcwrite", bus.PCWrite, 0);
    chk("rst_regwrite", bus.RegWrite, 0);
    chk("rst_sel", sel, 13'h0014);
    reset = 1'b1;
    run(32'hE2821005, 3, 4'h0, cyc, bm, rm, com);
    chk("add_cycles", cyc, 5);
    chk("add_busy", bm, 16'h001C);
    chk("add_regwrite", rm, 16'h0020);
    chk("add_commit", com, 13'h1014);
    run(32'hE0500000, 1, 4'b0100, cyc, bm, rm, com);
    chk("subs_cycles", cyc, 3);
    chk("subs_commit", com, 13'h1002);
    run(32'h0A000002, 1, 4'h0, cyc, bm, rm, com);
    chk("beq_taken_cycles", cyc, 3);
    chk("beq_taken_commit", com, 13'h04D4);
    run(32'hE0500000, 1, 4'h0, cyc, bm, rm, com);
    chk("subs_clr_cycles", cyc, 3);
    run(32'h02821005, 1, 4'h0, cyc, bm, rm, com);
    chk("addeq_cycles", cyc, 2);
    chk("addeq_busy", bm, 0);
    chk("addeq_commit", com, 13'h0014);
    run(32'h0A000002, 1, 4'h0, cyc, bm, rm, com);
    chk("beq_skip_cycles", cyc, 2);
    chk("beq_skip_commit", com, 13'h00D4);
    run(32'hE5843008, 1, 4'h0, cyc, bm, rm, com);
    chk("str_cycles", cyc, 3);
    chk("str_commit", com, 13'h0934);
    run(32'hE5943008, 4, 4'h0, cyc, bm, rm, com);
    chk("ldr_edge_cycles", cyc, 6);
    chk("ldr_edge_commit", com, 13'h1234);
    chk("ldr_edge_fault", bus.Fault, 0);
    run(32'hE282F005, 2, 4'h0, cyc, bm, rm, com);
    chk("add_pc_cycles", cyc, 4);
    chk("add_pc_commit", com, 13'h0414);
    run(32'hEC000000, 1, 4'h0, cyc, bm, rm, com);
    chk("undef_cycles", cyc, 2);
    chk("undef_busy", bm, 0);
    chk("undef_commit", com, 13'h0014);
    run(32'hF2821005, 1, 4'h0, cyc, bm, rm, com);
    chk("never_cycles", cyc, 2);
    run(32'hE2821005, 1, 4'b0100, cyc, bm, rm, com);
    run(32'h0A000002, 1, 4'h0, cyc, bm, rm, com);
    chk("no_s_flags_kept", cyc, 2);
    run(32'hE0500000, 1, 4'b1000, cyc, bm, rm, com);
    run(32'hBA000002, 1, 4'h0, cyc, bm, rm, com);
    chk("blt_taken_cycles", cyc, 3);
    run(32'hAA000002, 1, 4'h0, cyc, bm, rm, com);
    chk("bge_skip_cycles", cyc, 2);
    run(32'h1A000002, 1, 4'h0, cyc, bm, rm, com);
    chk("bne_taken_cycles", cyc, 3);
    bus.Instr = 32'hE2821005;
    bus.Finished = 1'b0;
    pw = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      #1;
      pw |= bus.PCWrite;
      tick;
    end
    chk("to_exec4_fault", bus.Fault, 0);
    chk("to_exec4_busy", bus.Busy, 1);
    tick;
    chk("to_fault", bus.Fault, 1);
    chk("to_fault_busy", bus.Busy, 0);
    for (int c = 0; c < 3; c++) begin
      pw |= bus.PCWrite;
      tick;
    end
    chk("to_fault_sticky", bus.Fault, 1);
    chk("to_no_pcwrite", pw, 0);
    reset = 1'b0;
    #1;
    chk("to_rst_fault", bus.Fault, 0);
    chk("to_rst_busy", bus.Busy, 0);
    reset = 1'b1;
    run(32'hE2821005, 2, 4'h0, cyc, bm, rm, com);
    chk("to_retry_cycles", cyc, 4);
    chk("to_retry_commit", com, 13'h1014);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Multi-cycle control unit for the ARM-subset datapath. Decodes the current instruction and drives every datapath mux select. Holds the PC while the iterative ALU computes, and commits register, memory and PC writes only after the ALU reports `Finished`. It also owns the NZCV flag register and conditional execution, and traps a hung ALU with a sticky fault.

## Interface
- `ALU_TIMEOUT`, default 15: maximum EXEC cycles allowed without `Finished`. Legal range is 1..255.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `Instr` in 32: current instruction. Bits [31:12] are used. Stable while `PCWrite`=0.
- `ALUFlags` in 4: {N,Z,C,V} from the ALU.
- `Finished` in 1: level signal from the ALU; 1 means `ALUResult`/`ALUFlags` are valid for the current operands.
- `RegSrc` out 2, `ImmSrc` out 2, `ALUSrc` out 1, `ALUControl` out 4, `MemToReg` out 1, `PCSrc` out 1: datapath selects.
- `RegWrite` out 1, `MemWrite` out 1, `PCWrite` out 1: write enables.
- `Busy` out 1: 1 in EXEC.
- `Fault` out 1: sticky ALU-timeout indication.

## Operation
- Decode fields: Cond=`Instr[31:28]`, Op=`Instr[27:26]`, Funct=`Instr[25:20]`, Rd=`Instr[15:12]`.
- Decode is combinational from `Instr` in all states.
- Op=00 (data processing):
  - `ALUControl`=Funct[4:1], `ALUSrc`=Funct[5], `ImmSrc`=00, `RegSrc`=00.
  - Writes Rd unless cmd is CMP (1010) or TST (1000).
  - Updates flags if Funct[0]=1 (S bit).
- Op=01 (memory):
  - `ALUControl`=0100 (add), `ALUSrc`=1, `ImmSrc`=01.
  - LDR (Funct[0]=1): `MemToReg`=1, writes Rd.
  - STR: `RegSrc`=10, `MemWrite` in COMMIT.
- Op=10 (branch): `RegSrc`=01, `ImmSrc`=10, `ALUSrc`=1, `ALUControl`=0100, `PCSrc`=1, no register write.
- Op=11 (undefined): NOP; treated as condition-failed.
- Rd=15 on an executed data-processing write or LDR: `PCSrc`=1, and `RegWrite`=0 for that instruction.
- Condition codes, evaluated against the registered flags:
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V).
  - AL 1; 1111 never.
- FSM states: DECODE, EXEC, COMMIT, FAULT.
  - DECODE: register CondEx. If CondEx=1, go to EXEC and clear the timeout counter; otherwise go to COMMIT.
  - EXEC: if `Finished`=1, capture `ALUFlags` into a pending register and go to COMMIT. Otherwise increment the counter; when it reaches `ALU_TIMEOUT` EXEC cycles, go to FAULT.
  - COMMIT (1 cycle): `PCWrite`=1. If CondEx=1, assert `RegWrite`/`MemWrite` per decode, and load flags from the pending register if the S bit is set. Then go to DECODE.
  - Condition-failed COMMIT: `PCSrc` forced to 0, no register/memory write, flags unchanged.
  - FAULT: `Fault`=1; all enables 0; held until reset.
- Enables (`RegWrite`, `MemWrite`, `PCWrite`) are 1 only in COMMIT; `Busy`=1 only in EXEC.

## Timing
- Reset asserted (`reset`=0), taking effect immediately and asynchronously:
  - state=DECODE; flags=0000; counter=0.
  - `Fault`, `Busy`, `RegWrite`, `MemWrite`, `PCWrite` = 0.
  - Select outputs follow the combinational decode of `Instr`.
- Reset mid-EXEC or mid-COMMIT aborts the instruction with no write. The same instruction is re-executed after release, since the PC was not advanced.
- Executed instruction whose `Finished` is first high in EXEC cycle k (k≥1): k+2 cycles total. `PCWrite`=1 in the final cycle.
- `Finished` already high on the first EXEC cycle: 3 cycles total.
- Condition-failed or undefined instruction: 2 cycles (DECODE, COMMIT).
- `Finished`=1 in the same cycle the counter expires: `Finished` wins and the FSM goes to COMMIT.
- A flag update from COMMIT is visible to the condition check of the immediately following DECODE.
- Select outputs remain stable from DECODE through COMMIT because `Instr` is stable.

## Test plan
- ADD R1,R2,#5 (0xE2821005), `Finished` rising on the 3rd EXEC cycle:
  - `ALUControl`=0100, `ALUSrc`=1 throughout.
  - `RegWrite`=`PCWrite`=1 only in cycle 5; `Busy`=1 in cycles 2–4.
- SUBS R0,R0,R0 (0xE0500000) with `ALUFlags`=0100 at `Finished`, followed by BEQ (0x0A000002):
  - BEQ reaches COMMIT with `PCSrc`=1, `PCWrite`=1, `RegWrite`=0.
- With flags Z=0, ADDEQ (0x02821005):
  - Completes in 2 cycles with `Busy` never 1.
  - `RegWrite`=0; `PCWrite`=1 with `PCSrc`=0.
- STR R3,[R4,#8] (0xE5843008):
  - `RegSrc`=10, `ImmSrc`=01, `MemWrite`=1 in COMMIT, `RegWrite`=0.
- LDR R3,[R4,#8] (0xE5943008):
  - `MemToReg`=1, `RegWrite`=1 in COMMIT, `MemWrite`=0.
- `ALU_TIMEOUT`=4, `Finished` held 0:
  - `Fault`=1 after 4 EXEC cycles; `PCWrite` never 1.
  - `reset` pulse low clears `Fault`, returns to DECODE, and the same instruction completes when `Finished` is later driven high.
